// File: rtl/paddle_pkg.sv
// Shared types and helpers for the paddle digitizer: per-channel state and
// the saturation limit of the scanline counter.
package paddle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CAPTURED = 2'd2
    } ch_state_t;

    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle channel: input synchronizer, rising-edge detect, capture FSM and
// publish registers. Optional averaging filter enabled by PADDLE_FILTER_EN.
module paddle_channel
    import paddle_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] line_cnt,
    input  logic             paddle,
    output logic [CNT_W-1:0] pos,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    ch_state_t              state, state_next;
    logic [CNT_W-1:0]       cap_q;
    logic [CNT_W-1:0]       pub_val;

    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], paddle};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: next state defaults to the current state first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (frame_start) state_next = ST_ARMED;
            ST_ARMED:    if (!frame_start && rise) state_next = ST_CAPTURED;
            ST_CAPTURED: if (frame_start) state_next = ST_ARMED;
            default:     state_next = ST_IDLE;
        endcase
    end

    // frame_start wins over a coincident edge: the capture is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q <= '0;
        end else if (state == ST_ARMED && !frame_start && rise) begin
            cap_q <= line_cnt;
        end
    end

`ifdef PADDLE_FILTER_EN
    logic hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 1'b0;
        end else if (frame_start) begin
            if (state == ST_ARMED)         hist_q <= 1'b0;
            else if (state == ST_CAPTURED) hist_q <= 1'b1;
        end
    end

    // pos still holds the last published value, so it serves as the history sample.
    assign pub_val = hist_q
        ? CNT_W'(({1'b0, pos} + {1'b0, cap_q} + (CNT_W+1)'(1)) >> 1)
        : cap_q;
`else
    assign pub_val = cap_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos     <= '0;
            timeout <= 1'b0;
        end else if (frame_start) begin
            case (state)
                ST_ARMED: begin
                    pos     <= ALL_ONES;
                    timeout <= 1'b1;
                end
                ST_CAPTURED: begin
                    pos     <= pub_val;
                    timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/paddle_capture.sv
// Multi-channel paddle digitizer top: shared saturating scanline counter,
// publish strobe and output packing. Filter option: PADDLE_FILTER_EN.
module paddle_capture
    import paddle_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    line_tick,
    input  logic [NUM_CH-1:0]       paddle_in,
    output logic [NUM_CH*CNT_W-1:0] pos,
    output logic                    pos_valid,
    output logic [NUM_CH-1:0]       timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] line_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_cnt <= '0;
        end else if (frame_start) begin
            line_cnt <= '0;
        end else if (line_tick && line_cnt != CNT_MAX) begin
            line_cnt <= line_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pos_valid <= 1'b0;
        else        pos_valid <= frame_start;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        paddle_channel #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .frame_start(frame_start),
            .line_cnt   (line_cnt),
            .paddle     (paddle_in[i]),
            .pos        (pos[i*CNT_W +: CNT_W]),
            .timeout    (timeout[i])
        );
    end

endmodule

// File: tb/tb_paddle_capture.sv
// Directed bench for paddle_capture (NUM_CH=2, CNT_W=8, SYNC_STAGES=2).
// Inputs change 1 ns after a rising edge; outputs are sampled on falling edges.
module tb_paddle_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_tick = 1'b0;
    logic [1:0]  paddle_in = 2'b00;
    logic [15:0] pos;
    logic        pos_valid;
    logic [1:0]  timeout;

    int checks = 0;
    int failures = 0;

`ifdef PADDLE_FILTER_EN
    bit         hist [2];
    logic [7:0] last [2];
`endif

    paddle_capture #(
        .NUM_CH     (2),
        .CNT_W      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .line_tick  (line_tick),
        .paddle_in  (paddle_in),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lines(input int n);
        repeat (n) begin
            @(posedge clk); #1 line_tick = 1'b1;
            @(posedge clk); #1 line_tick = 1'b0;
        end
    endtask

    task automatic rise(input int ch);
        paddle_in[ch] = 1'b1;
        idle(4);
    endtask

    // Raw per-channel expectations; the filter build folds them through the averaging rule.
    task automatic frame(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                         input logic [1:0] to, input bit idle_pub);
        logic [7:0]  r [2];
        logic [15:0] epos;
        r[0] = r0;
        r[1] = r1;
`ifdef PADDLE_FILTER_EN
        if (!idle_pub) begin
            for (int c = 0; c < 2; c++) begin
                if (to[c]) begin
                    hist[c] = 1'b0;
                    r[c] = 8'hFF;
                end else if (hist[c]) begin
                    r[c] = 8'(({1'b0, last[c]} + {1'b0, r[c]} + 9'd1) >> 1);
                end else begin
                    hist[c] = 1'b1;
                end
                last[c] = r[c];
            end
        end
`endif
        epos = idle_pub ? 16'h0000 : {r[1], r[0]};
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        check({tag, ".valid"}, pos_valid, 1'b1);
        check({tag, ".pos"}, pos, epos);
        check({tag, ".timeout"}, timeout, idle_pub ? 2'b00 : to);
        @(negedge clk);
        check({tag, ".valid_drop"}, pos_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        check("rst.pos", pos, 16'h0000);
        check("rst.valid", pos_valid, 1'b0);
        check("rst.timeout", timeout, 2'b00);
        @(posedge clk); #1 reset = 1'b1;

        // First frame after reset: channels IDLE, nothing new published.
        frame("idle0", 8'h00, 8'h00, 2'b00, 1'b1);
        lines(5);
        frame("no_edge", 8'hFF, 8'hFF, 2'b11, 1'b0);

        // Basic capture at lines 40 and 200.
        lines(40);
        rise(0);
        lines(160);
        rise(1);
        frame("basic", 8'd40, 8'd200, 2'b00, 1'b0);
        paddle_in = 2'b00;
        idle(4);

        // Repeated pulses on ch0: only the first counts.
        lines(10);
        paddle_in[0] = 1'b1; idle(2); paddle_in[0] = 1'b0; idle(4);
        lines(10);
        paddle_in[0] = 1'b1; idle(2); paddle_in[0] = 1'b0; idle(4);
        lines(10);
        paddle_in[0] = 1'b1; idle(2); paddle_in[0] = 1'b0; idle(4);
        rise(0);
        frame("pulses", 8'd10, 8'hFF, 2'b10, 1'b0);

        // ch0 held high across the whole frame: no edge, timeout.
        lines(20);
        rise(1);
        frame("held", 8'hFF, 8'd20, 2'b01, 1'b0);
        paddle_in = 2'b00;
        idle(4);

        // Counter saturation at 255 after 300 lines.
        lines(7);
        rise(1);
        lines(293);
        rise(0);
        frame("saturate", 8'hFF, 8'd7, 2'b00, 1'b0);
        paddle_in = 2'b00;
        idle(4);

        // ch0 edge lands in the frame_start cycle and is discarded.
        lines(15);
        rise(1);
        paddle_in[0] = 1'b1;
        @(posedge clk); #1;
        frame("coinc", 8'hFF, 8'd15, 2'b01, 1'b0);
        lines(5);
        frame("discarded", 8'hFF, 8'hFF, 2'b11, 1'b0);
        paddle_in = 2'b00;
        idle(4);

        // ch0 edge together with line_tick captures the pre-increment count.
        lines(33);
        paddle_in[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 line_tick = 1'b1;
        @(posedge clk); #1 line_tick = 1'b0;
        idle(2);
        lines(1);
        rise(1);
        frame("tick_edge", 8'd33, 8'd35, 2'b00, 1'b0);
        paddle_in = 2'b00;
        idle(4);

        // Reset mid-frame after ch0 captured 50.
        lines(50);
        rise(0);
        reset = 1'b0;
        #1;
        check("midrst.pos", pos, 16'h0000);
        check("midrst.timeout", timeout, 2'b00);
        check("midrst.valid", pos_valid, 1'b0);
        paddle_in = 2'b00;
`ifdef PADDLE_FILTER_EN
        hist[0] = 1'b0;
        hist[1] = 1'b0;
`endif
        @(posedge clk); #1 reset = 1'b1;
        frame("post_rst", 8'h00, 8'h00, 2'b00, 1'b1);
        lines(9);
        rise(0);
        frame("after_rst", 8'd9, 8'hFF, 2'b10, 1'b0);
        idle(3);
        check("hold.pos", pos, 16'hFF09);
        check("hold.timeout", timeout, 2'b10);
        paddle_in = 2'b00;
        idle(4);

`ifdef PADDLE_FILTER_EN
        // Averaging: 100 then 200 -> 150; timeout clears history; 60 published raw.
        lines(3);
        frame("f_clear", 8'hFF, 8'hFF, 2'b11, 1'b0);
        lines(100);
        rise(0);
        frame("f_100", 8'd100, 8'hFF, 2'b10, 1'b0);
        check("f_100.hand", pos[7:0], 8'd100);
        paddle_in = 2'b00;
        idle(4);
        lines(200);
        rise(0);
        frame("f_150", 8'd200, 8'hFF, 2'b10, 1'b0);
        check("f_150.hand", pos[7:0], 8'd150);
        paddle_in = 2'b00;
        idle(4);
        lines(2);
        frame("f_to", 8'hFF, 8'hFF, 2'b11, 1'b0);
        lines(60);
        rise(0);
        frame("f_60", 8'd60, 8'hFF, 2'b10, 1'b0);
        check("f_60.hand", pos[7:0], 8'd60);
        paddle_in = 2'b00;
        idle(4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
